// File: rtl/axisv_lcd_sink.sv
// AXI-Stream video sink driving a parallel LCD panel with free-running raster timing.
// Locks the incoming stream to the raster frame boundary and resynchronises on misalignment.
module axisv_lcd_sink #(
    parameter int H_PIXEL_COUNT   = 8,
    parameter int V_PIXEL_COUNT   = 4,
    parameter int H_FP            = 2,
    parameter int H_SYNC          = 1,
    parameter int H_BP            = 2,
    parameter int V_FP            = 1,
    parameter int V_SYNC          = 1,
    parameter int V_BP            = 1,
    parameter int DATA_WIDTH      = 18,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                  aclk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0] lcd_data_o,
    output logic                  lcd_de_o,
    output logic                  lcd_hsync_o,
    output logic                  lcd_vsync_o,
    output logic                  locked_o,
    output logic                  resync_o,
    output logic                  underflow_o
);
    localparam int H_TOT = H_PIXEL_COUNT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_PIXEL_COUNT + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT) + 1;
    localparam int VW    = $clog2(V_TOT) + 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_PIXEL_COUNT);
    localparam logic [VW-1:0] V_ACT      = VW'(V_PIXEL_COUNT);
    localparam logic [HW-1:0] H_EOL      = HW'(H_PIXEL_COUNT - 1);
    localparam logic [VW-1:0] V_EOF      = VW'(V_PIXEL_COUNT - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_PIXEL_COUNT + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_PIXEL_COUNT + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_PIXEL_COUNT + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_PIXEL_COUNT + V_FP + V_SYNC - 1);
    localparam logic          SYNC_IDLE  = SYNC_ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  de_q, de_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  resync_q, resync_d;
    logic                  underflow_q, underflow_d;

    logic active;
    logic frame_end;
    logic tready;
    logic locked;
    logic beat_accept;
    logic beat_mismatch;
    logic show_pixel;
    logic unused_tuser_bit;

    assign unused_tuser_bit = s_axis_tuser[1];

    // Raster counters run regardless of stream state so panel timing never stops.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    assign active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign frame_end   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign beat_accept = s_axis_tvalid && tready;

    // A locked beat must carry tlast exactly at the line end and EOF only on the last line's end.
    assign beat_mismatch = (s_axis_tlast != (h_cnt_q == H_EOL)) ||
                           (s_axis_tuser[0] != (s_axis_tlast && (v_cnt_q == V_EOF)));

    always_ff @(posedge aclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SEEK:   if (beat_accept && s_axis_tuser[0] && s_axis_tlast) state_d = ST_WAIT;
            ST_WAIT:   if (frame_end) state_d = ST_LOCKED;
            ST_LOCKED: if (beat_accept && beat_mismatch) state_d = ST_SEEK;
            default:   state_d = ST_SEEK;
        endcase
    end

    // tready depends only on the state register and raster counters.
    always_comb begin
        tready = 1'b0;
        locked = 1'b0;
        unique case (state_q)
            ST_SEEK:   tready = 1'b1;
            ST_WAIT:   tready = 1'b0;
            ST_LOCKED: begin
                tready = active;
                locked = 1'b1;
            end
            default:   tready = 1'b0;
        endcase
    end

    assign show_pixel = locked && active;

    always_comb begin
        data_d      = (show_pixel && s_axis_tvalid) ? s_axis_tdata : '0;
        de_d        = show_pixel;
        hsync_d     = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_d     = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? ~SYNC_IDLE : SYNC_IDLE;
        resync_d    = locked && beat_accept && beat_mismatch;
        underflow_d = underflow_q || (show_pixel && !s_axis_tvalid);
    end

    always_ff @(posedge aclk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            data_q      <= '0;
            de_q        <= 1'b0;
            hsync_q     <= SYNC_IDLE;
            vsync_q     <= SYNC_IDLE;
            resync_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            data_q      <= data_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            resync_q    <= resync_d;
            underflow_q <= underflow_d;
        end
    end

    assign s_axis_tready = tready;
    assign locked_o      = locked;
    assign lcd_data_o    = data_q;
    assign lcd_de_o      = de_q;
    assign lcd_hsync_o   = hsync_q;
    assign lcd_vsync_o   = vsync_q;
    assign resync_o      = resync_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_axisv_lcd_sink.sv
// Bench for axisv_lcd_sink: random-data AXIS source against a cycle-position reference model
// (raster position derived from cycles since reset, lock time from frame arithmetic).
module tb_axisv_lcd_sink;
    localparam int DW      = 18;
    localparam int H_ACT   = 8;
    localparam int V_ACT   = 4;
    localparam int H_TOT   = 13;
    localparam int V_TOT   = 7;
    localparam int FRAME   = H_TOT * V_TOT;
    localparam int HS_POS  = 10;
    localparam int VS_LINE = 5;

    logic          aclk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [1:0]    s_axis_tuser;
    logic [DW-1:0] lcd_data_o;
    logic          lcd_de_o;
    logic          lcd_hsync_o;
    logic          lcd_vsync_o;
    logic          locked_o;
    logic          resync_o;
    logic          underflow_o;

    axisv_lcd_sink dut (
        .aclk_i        (aclk_i),
        .rst_i         (rst_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .lcd_data_o    (lcd_data_o),
        .lcd_de_o      (lcd_de_o),
        .lcd_hsync_o   (lcd_hsync_o),
        .lcd_vsync_o   (lcd_vsync_o),
        .locked_o      (locked_o),
        .resync_o      (resync_o),
        .underflow_o   (underflow_o)
    );

    always #5 aclk_i = ~aclk_i;

    int total;
    int bad;

    // Reference model: position from cycle count, lock begins at a whole-frame boundary.
    int            t;
    bit            m_locked;
    bit            m_waiting;
    bit            m_uf;
    int            lock_at;
    logic [DW-1:0] exp_q[$];

    // Source state
    int            src_p;
    logic [DW-1:0] cur_data;
    bit            cur_last;
    bit            cur_eof;
    bit            short_pending;
    bit            drop_pending;
    int            mode;
    bit            last_acc;

    int resync_cnt;
    int tready_cnt;
    int de_cnt;
    int hs_fall[$];
    int vs_fall[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_beat();
        cur_data = DW'($urandom);
        cur_eof  = (src_p == 31);
        cur_last = (src_p % 8 == 7) || (short_pending && (src_p % 8 == 5));
    endtask

    task automatic drive();
        int h;
        int v;
        bit act;
        bit vld;
        h   = t % H_TOT;
        v   = (t / H_TOT) % V_TOT;
        act = (h < H_ACT) && (v < V_ACT);
        case (mode)
            0:       vld = 1'b0;
            1:       vld = 1'b1;
            default: vld = act ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        if (drop_pending && m_locked && h == 3 && v == 1) begin
            vld          = 1'b0;
            drop_pending = 1'b0;
        end
        s_axis_tvalid = vld;
        s_axis_tdata  = vld ? cur_data : DW'($urandom);
        s_axis_tlast  = cur_last;
        s_axis_tuser  = {1'($urandom_range(0, 1)), cur_eof};
    endtask

    task automatic step();
        int            h;
        int            v;
        bit            act;
        bit            exp_rdy;
        bit            acc;
        bit            bad_beat;
        bit            e_de;
        bit            e_hs;
        bit            e_vs;
        bit            e_rs;
        logic [DW-1:0] e_data;
        h   = t % H_TOT;
        v   = (t / H_TOT) % V_TOT;
        act = (h < H_ACT) && (v < V_ACT);
        exp_rdy = m_locked ? act : !m_waiting;
        chk("tready", s_axis_tready, exp_rdy);
        chk("locked", locked_o, m_locked);
        if (s_axis_tready) tready_cnt++;
        acc  = s_axis_tvalid && exp_rdy;
        e_de = m_locked && act;
        if (e_de) exp_q.push_back(s_axis_tvalid ? s_axis_tdata : '0);
        if (e_de && !s_axis_tvalid) m_uf = 1'b1;
        e_hs = (h != HS_POS);
        e_vs = (v != VS_LINE);
        bad_beat = (s_axis_tlast != (h == H_ACT - 1)) ||
                   (s_axis_tuser[0] != (s_axis_tlast && v == V_ACT - 1));
        e_rs = m_locked && acc && bad_beat;
        if (m_locked) begin
            if (e_rs) m_locked = 1'b0;
        end else if (!m_waiting) begin
            if (acc && s_axis_tlast && s_axis_tuser[0]) begin
                m_waiting = 1'b1;
                lock_at   = ((t + 1) / FRAME + 1) * FRAME;
            end
        end
        t++;
        if (m_waiting && t == lock_at) begin
            m_waiting = 1'b0;
            m_locked  = 1'b1;
        end
        last_acc = acc;
        @(posedge aclk_i);
        @(negedge aclk_i);
        chk("de", lcd_de_o, e_de);
        if (e_de) begin
            e_data = exp_q.pop_front();
            chk("data", lcd_data_o, e_data);
        end else begin
            chk("data_idle", lcd_data_o, 0);
        end
        chk("hsync", lcd_hsync_o, e_hs);
        chk("vsync", lcd_vsync_o, e_vs);
        chk("resync", resync_o, e_rs);
        chk("underflow", underflow_o, m_uf);
        if (resync_o) resync_cnt++;
        if (lcd_de_o) de_cnt++;
    endtask

    task automatic advance();
        if (last_acc) begin
            if (cur_last) begin
                if (src_p % 8 == 5) short_pending = 1'b0;
                src_p = ((src_p / 8 + 1) * 8) % 32;
            end else begin
                src_p++;
            end
            new_beat();
        end
    endtask

    task automatic cycle();
        drive();
        step();
        advance();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n;
        n = 0;
        while (!m_locked && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, locked_o, 1);
    endtask

    task automatic wait_frame_start();
        while (t % FRAME != 0) cycle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data"}, lcd_data_o, 0);
        chk({tag, "_de"}, lcd_de_o, 0);
        chk({tag, "_hsync"}, lcd_hsync_o, 1);
        chk({tag, "_vsync"}, lcd_vsync_o, 1);
        chk({tag, "_locked"}, locked_o, 0);
        chk({tag, "_resync"}, resync_o, 0);
        chk({tag, "_underflow"}, underflow_o, 0);
        chk({tag, "_tready"}, s_axis_tready, 1);
    endtask

    task automatic model_reset();
        t         = 0;
        m_locked  = 1'b0;
        m_waiting = 1'b0;
        m_uf      = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bit prev_hs;
        bit prev_vs;
        total = 0;
        bad   = 0;
        resync_cnt    = 0;
        tready_cnt    = 0;
        de_cnt        = 0;
        short_pending = 1'b0;
        drop_pending  = 1'b0;
        mode          = 0;
        src_p         = 0;
        new_beat();
        model_reset();

        // Clock/reset
        rst_i         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        repeat (3) @(negedge aclk_i);
        check_reset_values("reset");
        rst_i = 1'b0;

        // Raster with no source
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (prev_hs && !lcd_hsync_o) hs_fall.push_back(t);
            if (prev_vs && !lcd_vsync_o) vs_fall.push_back(t);
            prev_hs = lcd_hsync_o;
            prev_vs = lcd_vsync_o;
        end
        chk("hs_period", (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : 0, H_TOT);
        chk("hs_position", (hs_fall.size() >= 1) ? hs_fall[0] % H_TOT : 0, HS_POS + 1);
        chk("vs_period", (vs_fall.size() >= 2) ? vs_fall[1] - vs_fall[0] : 0, FRAME);

        // Lock and display: continuous source, first frame discarded
        mode  = 1;
        src_p = 0;
        new_beat();
        wait_lock("lock_first", 4 * FRAME);
        de_cnt = 0;
        run(2 * FRAME);
        chk("de_two_frames", de_cnt, 2 * H_ACT * V_ACT);

        // Underflow: one missing beat at pixel 3 of line 1
        resync_cnt   = 0;
        drop_pending = 1'b1;
        run(FRAME);
        wait_lock("relock_underflow", 4 * FRAME);
        chk("underflow_sticky", underflow_o, 1);
        chk("resync_underflow", resync_cnt, 1);
        run(FRAME);
        chk("underflow_held", underflow_o, 1);

        // Short line: tlast on pixel 5
        wait_frame_start();
        resync_cnt    = 0;
        short_pending = 1'b1;
        run(20);
        chk("short_resync", resync_cnt, 1);
        chk("short_unlocked", locked_o, 0);
        wait_lock("relock_short", 4 * FRAME);
        chk("short_resync_once", resync_cnt, 1);

        // Reset mid-frame at (v=2, h=4)
        wait_frame_start();
        run(2 * H_TOT + 4);
        #1 rst_i = 1'b1;
        #1 check_reset_values("async_reset");
        @(posedge aclk_i);
        @(negedge aclk_i);
        rst_i = 1'b0;
        model_reset();

        // Backpressure only in blanking after relock
        mode = 2;
        wait_lock("relock_after_reset", 4 * FRAME);
        wait_frame_start();
        tready_cnt = 0;
        run(2 * FRAME);
        chk("tready_two_frames", tready_cnt, 2 * H_ACT * V_ACT);
        chk("bp_no_underflow", underflow_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
